// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: button inputs and counter/display outputs of the stopwatch controller
//   master: drives btn_start_n/btn_lap_n/btn_clear_n, observes the outputs
//   slave : the controller; receives the buttons, drives count, disp_value,
//           running, lap_active, tick, wrap
interface stopwatch_ctrl_if;
    logic        btn_start_n;
    logic        btn_lap_n;
    logic        btn_clear_n;
    logic [15:0] count;
    logic [15:0] disp_value;
    logic        running;
    logic        lap_active;
    logic        tick;
    logic        wrap;

    modport master (
        output btn_start_n, btn_lap_n, btn_clear_n,
        input  count, disp_value, running, lap_active, tick, wrap
    );

    modport slave (
        input  btn_start_n, btn_lap_n, btn_clear_n,
        output count, disp_value, running, lap_active, tick, wrap
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear controller for a 16-bit display counter
//   CLOCK  : system clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : stopwatch_ctrl_if.slave
//            btn_*_n in (active-low, asynchronous), count/disp_value out (16),
//            running/lap_active/tick/wrap out (1)
//   PRESCALE : system cycles per count tick (>= 1)
//   DEBOUNCE : stable cycles required for a button level change
//   Define STOPWATCH_CTRL_DEBOUNCE_EN to insert the debounce filter.
module stopwatch_ctrl #(
    parameter int PRESCALE = 50000,
    parameter int DEBOUNCE = 65536
) (
    input logic           CLOCK,
    input logic           reset,
    stopwatch_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] LAP   = 2'd3;
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    // button vectors: bit 0 start, bit 1 lap, bit 2 clear
    logic [2:0]    raw, s1, s2, lvl, prev, armed, ev;
    logic [1:0]    fill;
    logic [1:0]    state, nxt;
    logic [PW-1:0] pre;
    logic [15:0]   cnt, lap;
    logic          active, ev_clr, ev_start, ev_lap;

    assign raw = {bus.btn_clear_n, bus.btn_lap_n, bus.btn_start_n};

    // A button only arms once the synchronizer has carried a real released
    // level (fill marks the chain as flushed of its reset value), so a button
    // held through reset release yields no event until released and re-pressed.
    always_ff @(posedge CLOCK or negedge reset)
        if (!reset) begin
            s1    <= '1;
            s2    <= '1;
            prev  <= '1;
            armed <= '0;
            fill  <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            prev  <= lvl;
            armed <= armed | (s2 & {3{fill[1]}});
            fill  <= {fill[0], 1'b1};
        end

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE + 1);
    for (genvar i = 0; i < 3; i++) begin : g_db
        logic          f;
        logic [DW-1:0] c;
        // any cycle agreeing with the filtered level restarts the run length
        always_ff @(posedge CLOCK or negedge reset)
            if (!reset) begin
                f <= 1'b1;
                c <= '0;
            end else if (s2[i] == f) begin
                c <= '0;
            end else if (c == DW'(DEBOUNCE - 1)) begin
                f <= s2[i];
                c <= '0;
            end else begin
                c <= c + 1'b1;
            end
        assign lvl[i] = f;
    end
`else
    assign lvl = s2;
`endif

    assign ev       = armed & prev & ~lvl;
    assign ev_clr   = ev[2];
    assign ev_start = ev[0] & ~ev[2];
    assign ev_lap   = ev[1] & ~ev[0] & ~ev[2];

    assign active = (state == RUN) || (state == LAP);
    assign nxt = ev_clr                      ? IDLE :
                 ev_start                    ? (active ? PAUSE : RUN) :
                 ev_lap && state == RUN      ? LAP :
                 ev_lap && state == LAP      ? RUN : state;

    assign bus.tick       = active && pre == PMAX;
    assign bus.wrap       = bus.tick && cnt == 16'hFFFF;
    assign bus.count      = cnt;
    assign bus.disp_value = state == LAP ? lap : cnt;

    // entering IDLE wins over a coincident tick: the increment is dropped
    always_ff @(posedge CLOCK or negedge reset)
        if (!reset) begin
            state          <= IDLE;
            pre            <= '0;
            cnt            <= '0;
            lap            <= '0;
            bus.running    <= 1'b0;
            bus.lap_active <= 1'b0;
        end else begin
            state          <= nxt;
            bus.running    <= nxt == RUN || nxt == LAP;
            bus.lap_active <= nxt == LAP;
            if (state == RUN && nxt == LAP)
                lap <= cnt;
            if (nxt == IDLE) begin
                pre <= '0;
                cnt <= '0;
            end else if (bus.tick) begin
                pre <= '0;
                cnt <= cnt + 16'd1;
            end else if (active) begin
                pre <= pre + 1'b1;
            end
        end
endmodule
